bp_reg_bank_write_arb: RTL and testbench

Round-robin write arbiter and clear sequencer for a small bank of enable-loaded, width_p-bit data registers. Up to num_req_p requesters each offer one address/data write per cycle. The block grants at most one per cycle, loads the selected entry, and exposes the bank on a combinational read port. After reset, or on command, a sequencer walks every entry to zero before any writes are granted. It sits between the pipeline stages that produce configuration/tag words and the consumers that read them.

---
 rtl/bp_reg_bank_write_arb_pkg.sv | 20 ++
 rtl/bp_rr_arb_onehot.sv | 38 +++
 rtl/bp_reg_bank_write_arb.sv | 133 +++++++++++++
 tb/tb_bp_reg_bank_write_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_reg_bank_write_arb_pkg.sv
// Shared types and constants for the bp_reg_bank_write_arb register bank.
// Build option: BP_REG_BANK_BYPASS_EN (used by the top module).
package bp_reg_bank_write_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned WIDTH_DEFAULT = 28;
    localparam int unsigned ELS_DEFAULT   = 8;

    // Index width for n items; never below 1 so vectors stay legal.
    function automatic int unsigned lg(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LG_ELS_DEFAULT = lg(ELS_DEFAULT);

endpackage

// File: rtl/bp_rr_arb_onehot.sv
// Combinational round-robin arbiter: one-hot grant to the first valid
// requester at or above ptr_i, wrapping modulo num_req_p.
module bp_rr_arb_onehot
    import bp_reg_bank_write_arb_pkg::*;
#(
    parameter  int unsigned num_req_p = 4,
    localparam int unsigned lg_req_lp = lg(num_req_p)
) (
    input  logic [num_req_p-1:0] v_i,
    input  logic [lg_req_lp-1:0] ptr_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [lg_req_lp-1:0] grant_idx_o,
    output logic                 grant_v_o
);

    int unsigned          idx;
    logic [lg_req_lp-1:0] idx_sel;

    // NOTE: every output gets a default before the search loop; a path that
    // leaves a signal unassigned in always_comb would infer a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_v_o   = 1'b0;
        idx         = 0;
        idx_sel     = '0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            idx     = (32'(ptr_i) + k) % num_req_p;
            idx_sel = lg_req_lp'(idx);
            if (!grant_v_o && v_i[idx_sel]) begin
                grant_v_o        = 1'b1;
                grant_o[idx_sel] = 1'b1;
                grant_idx_o      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/bp_reg_bank_write_arb.sv
// Round-robin write arbiter and clear sequencer over a small register bank.
// Define BP_REG_BANK_BYPASS_EN to forward same-cycle writes to r_data_o.
module bp_reg_bank_write_arb
    import bp_reg_bank_write_arb_pkg::*;
#(
    parameter  int unsigned num_req_p = 4,
    parameter  int unsigned els_p     = ELS_DEFAULT,
    parameter  int unsigned width_p   = WIDTH_DEFAULT,
    localparam int unsigned lg_els_lp = lg(els_p),
    localparam int unsigned lg_req_lp = lg(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic [num_req_p-1:0]           v_i,
    input  logic [num_req_p*lg_els_lp-1:0] addr_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    output logic [num_req_p-1:0]           yumi_o,
    input  logic [lg_els_lp-1:0]           r_addr_i,
    output logic [width_p-1:0]             r_data_o,
    output logic                           busy_o
);

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic [lg_els_lp-1:0] clr_ptr_q, clr_ptr_d;
    logic [lg_req_lp-1:0] prio_q, prio_d;

    logic [width_p-1:0]   bank_q [els_p];
    logic [els_p-1:0]     bank_en;

    logic                 wr_v;
    logic [lg_els_lp-1:0] wr_addr;
    logic [width_p-1:0]   wr_data;

    logic [num_req_p-1:0] arb_v;
    logic [num_req_p-1:0] grant;
    logic [lg_req_lp-1:0] grant_idx;
    logic                 grant_v;

    // clear_i masks requests so it wins over every write in the same cycle.
    assign arb_v = (state_q == READY && !clear_i) ? v_i : '0;

    bp_rr_arb_onehot #(
        .num_req_p (num_req_p)
    ) u_arb (
        .v_i         (arb_v),
        .ptr_i       (prio_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_v_o   (grant_v)
    );

    assign yumi_o = grant;
    assign busy_o = busy_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        prio_d    = prio_q;
        wr_v      = 1'b0;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        unique case (state_q)
            CLEAR: begin
                wr_v = 1'b1;
                if (clr_ptr_q == lg_els_lp'(els_p - 1)) begin
                    state_d   = READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + lg_els_lp'(1);
                end
            end
            READY: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else if (grant_v) begin
                    wr_v    = 1'b1;
                    wr_addr = addr_i[grant_idx*lg_els_lp +: lg_els_lp];
                    wr_data = data_i[grant_idx*width_p +: width_p];
                    prio_d  = (grant_idx == lg_req_lp'(num_req_p - 1))
                              ? '0 : grant_idx + lg_req_lp'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_ptr_q <= '0;
            prio_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            clr_ptr_q <= clr_ptr_d;
            prio_q    <= prio_d;
        end
    end

    always_comb begin
        bank_en = '0;
        for (int unsigned e = 0; e < els_p; e++) begin
            bank_en[e] = wr_v && (wr_addr == lg_els_lp'(e));
        end
    end

    // NOTE: the bank has no reset; the clear sequencer zeroes it instead,
    // which keeps the storage plain enable flops without a reset tree.
    always_ff @(posedge clk_i) begin
        for (int unsigned e = 0; e < els_p; e++) begin
            if (bank_en[e]) begin
                bank_q[e] <= wr_data;
            end
        end
    end

    always_comb begin
        r_data_o = bank_q[r_addr_i];
`ifdef BP_REG_BANK_BYPASS_EN
        if (wr_v && wr_addr == r_addr_i) begin
            r_data_o = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_bp_reg_bank_write_arb.sv
// Randomized and directed bench for bp_reg_bank_write_arb against a
// cycle-level behavioural model of the bank, clear walk and round-robin rule.
module tb_bp_reg_bank_write_arb;

    localparam int N  = 4;
    localparam int E  = 8;
    localparam int W  = 28;
    localparam int LA = 3;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           clear_i;
    logic [N-1:0]   v_i;
    logic [N*LA-1:0] addr_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   yumi_o;
    logic [LA-1:0]  r_addr_i;
    logic [W-1:0]   r_data_o;
    logic           busy_o;

    bp_reg_bank_write_arb #(
        .num_req_p (N),
        .els_p     (E),
        .width_p   (W)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (clear_i),
        .v_i      (v_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .yumi_o   (yumi_o),
        .r_addr_i (r_addr_i),
        .r_data_o (r_data_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bank contents with a known flag, clear progress, priority.
    bit         m_clearing;
    int         m_clr;
    int         m_prio;
    logic [W-1:0] m_bank [E];
    bit         m_known [E];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_clr      = 0;
        m_prio     = 0;
    endtask

    function automatic int model_grant();
        if (m_clearing || clear_i) return -1;
        for (int k = 0; k < N; k++) begin
            if (v_i[(m_prio + k) % N]) return (m_prio + k) % N;
        end
        return -1;
    endfunction

    function automatic int addr_of(input int g);
        return int'(addr_i[g*LA +: LA]);
    endfunction

    function automatic logic [W-1:0] data_of(input int g);
        return data_i[g*W +: W];
    endfunction

    task automatic set_req(input int i, input bit v, input int a, input logic [W-1:0] d);
        v_i[i]           = v;
        addr_i[i*LA +: LA] = LA'(a);
        data_i[i*W +: W]   = d;
    endtask

    // Called at a negedge with inputs driven; checks, clocks, advances the model.
    task automatic step(input string tag);
        int           g;
        logic [N-1:0] exp_yumi;
        logic [W-1:0] exp_rd;
        bit           rd_known;
        #1;
        g        = model_grant();
        exp_yumi = '0;
        if (g >= 0) exp_yumi[g] = 1'b1;
        check({tag, " yumi"}, 32'(yumi_o), 32'(exp_yumi));
        check({tag, " busy"}, 32'(busy_o), 32'(m_clearing));
        rd_known = m_known[r_addr_i];
        exp_rd   = m_bank[r_addr_i];
`ifdef BP_REG_BANK_BYPASS_EN
        if (m_clearing && m_clr == int'(r_addr_i)) begin
            rd_known = 1'b1;
            exp_rd   = '0;
        end
        if (g >= 0 && addr_of(g) == int'(r_addr_i)) begin
            rd_known = 1'b1;
            exp_rd   = data_of(g);
        end
`endif
        if (rd_known) check({tag, " rdata"}, 32'(r_data_o), 32'(exp_rd));
        @(posedge clk_i);
        if (m_clearing) begin
            m_bank[m_clr]  = '0;
            m_known[m_clr] = 1'b1;
            if (m_clr == E - 1) begin
                m_clearing = 1'b0;
                m_clr      = 0;
            end else begin
                m_clr++;
            end
        end else if (clear_i) begin
            m_clearing = 1'b1;
            m_clr      = 0;
        end else if (g >= 0) begin
            m_bank[addr_of(g)]  = data_of(g);
            m_known[addr_of(g)] = 1'b1;
            m_prio              = (g + 1) % N;
        end
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           busy_len;
        logic [W-1:0] old3;
        logic [N-1:0] rr_seq [5];

        for (int e = 0; e < E; e++) begin
            m_known[e] = 1'b0;
            m_bank[e]  = '0;
        end
        reset_i  = 1'b1;
        clear_i  = 1'b0;
        v_i      = '0;
        addr_i   = '0;
        data_i   = '0;
        r_addr_i = '0;
        model_reset();
        #1;
        check("reset busy", 32'(busy_o), 32'd1);
        check("reset yumi", 32'(yumi_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Reset then idle: exactly E busy cycles, then all entries read zero.
        busy_len = 0;
        while (busy_o && busy_len < 20) begin
            busy_len++;
            step("init_clear");
        end
        check("init clear length", 32'(busy_len), 32'(E));
        for (int a = 0; a < E; a++) begin
            r_addr_i = LA'(a);
            #1;
            check("init zero", 32'(r_data_o), 32'd0);
            step("init_read");
        end

        // Round-robin with all four requesters held.
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i, W'(32'hA000000 + i));
        for (int s = 0; s < 5; s++) begin
            #1;
            check("rr order", 32'(yumi_o), 32'(rr_seq[s]));
            step("rr");
        end
        v_i = '0;
        for (int a = 0; a < N; a++) begin
            r_addr_i = LA'(a);
            #1;
            check("rr data", 32'(r_data_o), 32'hA000000 + 32'(a));
            step("rr_read");
        end

        // Skip and priority: grant 1, then 0011 wraps from 2 to grant 0, then 1.
        v_i = 4'b0010;
        step("skip_a");
        v_i = 4'b0011;
        #1;
        check("skip wrap", 32'(yumi_o), 32'b0001);
        step("skip_b");
        v_i = 4'b0010;
        #1;
        check("skip next", 32'(yumi_o), 32'b0010);
        step("skip_c");

        // Clear command with requesters pending.
        v_i     = 4'b1111;
        clear_i = 1'b1;
        #1;
        check("clear no grant", 32'(yumi_o), 32'd0);
        step("clear_cmd");
        clear_i  = 1'b0;
        busy_len = 0;
        while (busy_o && busy_len < 20) begin
            busy_len++;
            step("cmd_clear");
        end
        check("cmd clear length", 32'(busy_len), 32'(E));
        step("post_clear_grant");
        v_i = '0;
        for (int a = 0; a < E; a++) begin
            r_addr_i = LA'(a);
            step("post_clear_read");
        end

        // Same-cycle read of entry 3 while it is being written.
        old3 = m_bank[3];
        set_req(2, 1'b1, 3, W'(32'h5555555));
        r_addr_i = 3'd3;
        m_prio   = m_prio;
        #1;
`ifdef BP_REG_BANK_BYPASS_EN
        check("rdw bypass", 32'(r_data_o), 32'h5555555);
`else
        check("rdw old", 32'(r_data_o), 32'(old3));
`endif
        step("rdw");
        v_i = '0;
        #1;
        check("rdw after", 32'(r_data_o), 32'h5555555);
        step("rdw_after");

        // Randomized traffic with occasional clear commands.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, E - 1)),
                        W'($urandom));
            end
            clear_i  = ($urandom_range(0, 39) == 0);
            r_addr_i = LA'($urandom_range(0, E - 1));
            step("rand");
        end
        clear_i = 1'b0;

        // Async reset mid-clear at pointer 5, requesters active.
        clear_i = 1'b1;
        step("mid_clear_cmd");
        clear_i = 1'b0;
        v_i     = 4'b1111;
        for (int s = 0; s < 5; s++) step("mid_clear_walk");
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("midreset busy", 32'(busy_o), 32'd1);
        check("midreset yumi", 32'(yumi_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i  = 1'b0;
        busy_len = 0;
        while (busy_o && busy_len < 20) begin
            busy_len++;
            step("mid_reclear");
        end
        check("midreset clear length", 32'(busy_len), 32'(E));
        for (int s = 0; s < 4; s++) step("mid_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
